// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin arbiter sharing one up-counter among timed-interval requesters
module counter_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  cnt_reset,
  output logic                  cnt_enable,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic                  abort,
  output logic [ID_W-1:0]       done_id
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  ptr, id_q, winner;
  logic [WIDTH-1:0] len_q;
  logic             abort_q, abort_next, found;

  // First asserted request at or after ptr, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        winner = ID_W'((int'(ptr) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    abort_next = abort_q;
    grant      = '0;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_next = CLEAR;
      end
      CLEAR: begin
        grant[id_q] = 1'b1;
        cnt_reset   = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        grant[id_q] = 1'b1;
        cnt_enable  = (cnt_value < len_q);
        // A dropped request wins over completion; >= covers any overshoot.
        if (!req[id_q]) begin
          state_next = DONE;
          abort_next = 1'b1;
        end else if (cnt_value >= len_q) begin
          state_next = DONE;
          abort_next = 1'b0;
        end
      end
      DONE: begin
        done       = 1'b1;
        abort      = abort_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy = |grant;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      id_q    <= '0;
      len_q   <= '0;
      abort_q <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_next;
      abort_q <= abort_next;
      if (state == IDLE && found) begin
        id_q  <= winner;
        len_q <= len[int'(winner)*WIDTH +: WIDTH];
      end
      // Loaded on entry to DONE so it is valid with the pulse and holds after.
      if (state == RUN && state_next == DONE) done_id <= id_q;
      if (state == DONE) ptr <= (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - self-checking bench for counter_scheduler with a counter model and done scoreboard
module tb_counter_scheduler;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [WIDTH-1:0]      cnt_value = 4'd9;
  logic                  cnt_reset, cnt_enable, busy, done, abort;
  logic [NREQ-1:0]       grant;
  logic [ID_W-1:0]       done_id;

  counter_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clock(clock), .reset(reset), .req(req), .len(len), .cnt_value(cnt_value),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .grant(grant), .busy(busy),
    .done(done), .abort(abort), .done_id(done_id)
  );

  always #5 clock = ~clock;

  // Shared counter: not touched by the scheduler reset.
  always @(posedge clock) begin
    if (cnt_reset) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 1'b1;
  end

  typedef struct {
    int id;
    int ab;
    int cnt;
    int en;
    int gnt;
  } exp_t;

  typedef struct {
    int id;
    int l;
    int drop;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int id, input int ab, input int c, input int e, input int g);
    exp_t x;
    x.id = id; x.ab = ab; x.cnt = c; x.en = e; x.gnt = g;
    sb.push_back(x);
  endfunction

  // Monitor: interval statistics, invariants and scoreboard comparison at done.
  initial begin
    int gnt_cyc, en_cyc;
    logic [NREQ-1:0] prev_grant;
    exp_t e;
    gnt_cyc = 0; en_cyc = 0; prev_grant = '0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        gnt_cyc = 0; en_cyc = 0; prev_grant = '0;
      end else begin
        checks++;
        if (!$onehot0(grant) || (done && grant != 0) || (busy != (grant != 0))) begin
          errors++;
          $display("FAIL invariant: grant=%b busy=%b done=%b", grant, busy, done);
        end
        if (grant != 0 && prev_grant == 0) begin
          checks++;
          if (!cnt_reset) begin
            errors++;
            $display("FAIL first_grant_clear: cnt_reset=%b required 1", cnt_reset);
          end
        end
        if (cnt_enable) begin
          checks++;
          if (cnt_value == 4'd15) begin
            errors++;
            $display("FAIL no_wrap: cnt_enable high with cnt_value=15");
          end
        end
        if (grant != 0) gnt_cyc++;
        if (cnt_enable) en_cyc++;
        if (done) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done_id=%0d with empty scoreboard", done_id);
          end else begin
            e = sb.pop_front();
            if (int'(done_id) != e.id || int'(abort) != e.ab || int'(cnt_value) != e.cnt ||
                en_cyc != e.en || gnt_cyc != e.gnt) begin
              errors++;
              $display("FAIL done_rec: got id=%0d abort=%0d cnt=%0d en=%0d gnt=%0d expected id=%0d abort=%0d cnt=%0d en=%0d gnt=%0d",
                       done_id, abort, cnt_value, en_cyc, gnt_cyc, e.id, e.ab, e.cnt, e.en, e.gnt);
            end
          end
          gnt_cyc = 0; en_cyc = 0;
        end
        prev_grant = grant;
      end
    end
  end

  // Single-requester interval; drop > 0 releases req after that many enabled cycles.
  task automatic run_vec(input int id, input int l, input int drop);
    logic [WIDTH-1:0] lv;
    int lat, enc, got;
    lv = l[WIDTH-1:0];
    if (drop > 0) push_exp(id, 1, drop, drop, drop + 1);
    else          push_exp(id, 0, l, l, l + 2);
    len[id*WIDTH +: WIDTH] = lv;
    @(negedge clock);
    req[id] = 1'b1;
    lat = 0; enc = 0; got = 0;
    for (int t = 0; t < 60 && got == 0; t++) begin
      @(negedge clock);
      lat++;
      if (t == 1) len[id*WIDTH +: WIDTH] = ~lv;
      if (cnt_enable) enc++;
      if (done) begin
        got = 1;
        req[id] = 1'b0;
      end else if (drop > 0 && enc == drop && req[id]) begin
        req[id] = 1'b0;
      end
    end
    chk($sformatf("done_seen_id%0d_len%0d", id, l), got, 1);
    if (drop <= 0) chk($sformatf("latency_id%0d_len%0d", id, l), lat, l + 3);
    @(negedge clock);
    @(negedge clock);
    chk("done_id_hold", int'(done_id), id);
    chk("done_low_after", int'(done), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int nd, cyc, last, enc, seen_first;
    int gaps[$];
    logic [NREQ-1:0] first_grant;

    vecs[0] = '{1, 10, 3};
    vecs[1] = '{0, 0, -1};
    vecs[2] = '{1, 7, 2};
    vecs[3] = '{2, 5, -1};
    vecs[4] = '{0, 1, -1};
    vecs[5] = '{3, 15, -1};

    reset = 1'b0; req = '0; len = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_grant", int'(grant), 0);
    chk("rst_ctrl", int'({cnt_reset, cnt_enable, busy, done, abort}), 0);
    chk("rst_done_id", int'(done_id), 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_quiet", int'({grant, cnt_reset, cnt_enable, done}), 0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i].id, vecs[i].l, vecs[i].drop);

    // All four requesting, len 1 each, pointer at 0.
    len = 16'h1111;
    push_exp(0, 0, 1, 1, 3); push_exp(1, 0, 1, 1, 3); push_exp(2, 0, 1, 1, 3);
    push_exp(3, 0, 1, 1, 3); push_exp(0, 0, 1, 1, 3);
    @(negedge clock);
    req = 4'b1111;
    nd = 0; cyc = 0; last = 0;
    for (int t = 0; t < 100 && nd < 5; t++) begin
      @(negedge clock);
      cyc++;
      if (done) begin
        if (nd > 0) gaps.push_back(cyc - last);
        last = cyc;
        nd++;
        if (nd == 5) req = '0;
      end
    end
    chk("rr_done_count", nd, 5);
    foreach (gaps[i]) chk("rr_period", gaps[i], 5);

    // Pointer is now 1: requester 1 aborts after 3 enabled cycles, then 2 and 3 follow.
    len = 16'h11A1;
    push_exp(1, 1, 3, 3, 4); push_exp(2, 0, 1, 1, 3); push_exp(3, 0, 1, 1, 3);
    @(negedge clock);
    req = 4'b1110;
    nd = 0; enc = 0;
    for (int t = 0; t < 100 && nd < 3; t++) begin
      @(negedge clock);
      if (grant[1] && cnt_enable) enc++;
      if (enc == 3 && req[1]) req[1] = 1'b0;
      if (done) begin
        nd++;
        if (nd == 3) req = '0;
      end
    end
    chk("abort_seq_done_count", nd, 3);

    // Move the pointer to 2, then reset in the middle of an interval.
    run_vec(1, 2, -1);
    len[2*WIDTH +: WIDTH] = 4'd8;
    @(negedge clock);
    req = 4'b0100;
    nd = 0;
    for (int t = 0; t < 30 && nd == 0; t++) begin
      @(negedge clock);
      if (grant[2] && cnt_value == 4'd3) nd = 1;
    end
    chk("reached_mid_run", nd, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_ctrl", int'({cnt_reset, cnt_enable, busy, done, abort}), 0);
    chk("async_rst_done_id", int'(done_id), 0);
    @(negedge clock);
    req = 4'b1001;
    len[0 +: WIDTH] = 4'd2;
    len[3*WIDTH +: WIDTH] = 4'd1;
    push_exp(0, 0, 2, 2, 4); push_exp(3, 0, 1, 1, 3);
    reset = 1'b1;
    nd = 0; seen_first = 0; first_grant = '0;
    for (int t = 0; t < 60 && nd < 2; t++) begin
      @(negedge clock);
      if (seen_first == 0 && grant != 0) begin
        seen_first = 1;
        first_grant = grant;
        chk("post_rst_clear", int'(cnt_reset), 1);
      end
      if (done) begin
        nd++;
        if (nd == 2) req = '0;
      end
    end
    chk("post_rst_first_grant", int'(first_grant), 1);
    chk("post_rst_done_count", nd, 2);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares a single 4-bit up-counter among several requesters, each asking for a timed interval of a programmed length. It sits in front of the counter and drives the counter's synchronous clear and count-enable. It watches the count value and reports completion or abort back to the requester that held the grant.

## Interface
- `WIDTH`, 4: counter width; also the width of each requested length.
- `NREQ`, 4: number of requesters. ID_W = $clog2(NREQ).
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester level request; must be held until `done`.
- `len` in NREQ*WIDTH: packed interval lengths, requester i at [i*WIDTH +: WIDTH]; range 0..2^WIDTH-1.
- `cnt_value` in WIDTH: current value of the shared counter.
- `cnt_reset` out 1: synchronous active-high clear to the counter.
- `cnt_enable` out 1: count enable to the counter.
- `grant` out NREQ: one-hot owner of the counter; all-zero when free.
- `busy` out 1: OR of `grant`.
- `done` out 1: one-cycle completion pulse.
- `abort` out 1: qualifies `done`; the interval ended early because the owner dropped `req`.
- `done_id` out ID_W: requester index for `done`; holds its value until the next `done`.

## Operation
- Counter contract: on each rising edge, if `cnt_reset` is high the counter goes to 0; otherwise, if `cnt_enable` is high, it increments.
- **IDLE**
  - Outputs `cnt_reset`, `cnt_enable` and `grant` are all 0.
  - If any `req` bit is set, select a winner by round-robin, starting at priority pointer `ptr`.
  - Latch the winner's id into `id_q` and its length into `len_q`, then go to CLEAR.
  - Later changes on `len` are ignored.
- **CLEAR**
  - `grant[id_q]` = 1 and `cnt_reset` = 1 for exactly one cycle.
  - Go to RUN unconditionally; `req` is not checked in this state.
- **RUN**
  - `grant[id_q]` = 1 and `cnt_enable` = (`cnt_value` < `len_q`), combinational.
  - If `req[id_q]` = 0: go to DONE with abort flagged. This has priority over completion.
  - Else if `cnt_value` >= `len_q`: go to DONE (normal completion). Using >= guards against wrap-around.
- **DONE**
  - `grant` = 0, `cnt_enable` = 0, `done` = 1, `abort` per flag, `done_id` = `id_q`.
  - Set `ptr` = `id_q`+1 modulo NREQ, then go to IDLE.
- Round-robin: the winner is the first set `req` bit at or after `ptr`, wrapping. After reset `ptr` = 0, so requester 0 has highest priority.
- `len` = 0 is legal: RUN lasts one cycle with `cnt_enable` = 0, then a normal `done`.
- Reset (async, any state):
  - State goes to IDLE, `ptr` = 0.
  - All outputs go to 0, including `done_id`.
  - The counter itself is not cleared by this reset; the next grant clears it in CLEAR.

## Timing
- Request sampled in IDLE at edge E:
  - CLEAR in cycle E+1.
  - RUN from E+2 through E+2+`len`, with `cnt_enable` high for exactly `len` cycles.
  - DONE in cycle E+3+`len`.
  - Back in IDLE in cycle E+4+`len`.
- Request-to-`done` latency: `len`+3 cycles. No interval is extended or truncated except by abort.
- Back-to-back requests: the next CLEAR comes 2 cycles after DONE (one IDLE cycle). Overhead is 4 cycles per interval.
- Abort: if `req[id_q]` is low at a RUN edge, the next cycle is DONE with `abort` = 1. `cnt_value` freezes at its current value.
- `grant` is one-hot or zero at all times. `done` is never high in the same cycle as `grant`.

## Test plan
- Reset with `req` = 0 -> all outputs 0. Release reset and pulse nothing -> outputs stay 0 and the FSM stays in IDLE.
- `req`[2] = 1, `len`[2] = 5 -> `grant` = 4'b0100 for 7 cycles. `cnt_reset` is high in the first of them. `cnt_enable` is high for exactly 5 cycles. `done` = 1 with `done_id` = 2 and `abort` = 0, 8 cycles after the sampling edge; `cnt_value` = 5.
- `req` = 4'b1111, all `len` = 1, held continuously -> grant order 0,1,2,3,0. Each interval is 4 cycles plus 1 IDLE cycle. Every `done` has `abort` = 0.
- `req`[1] with `len` = 10, dropped after 3 enabled RUN cycles -> `done` = 1 with `abort` = 1 and `done_id` = 1; `cnt_value` holds at 3. `ptr` advances so requester 2 wins next.
- `len` = 0 and `len` = 15 (max) on separate requests -> `cnt_enable` is high for 0 and 15 cycles respectively. `cnt_value` never wraps past 15. Both finish with normal `done`.
- Assert `reset` low in the middle of RUN -> `grant`, `cnt_enable`, `done` and `done_id` go to 0 immediately. After release, a pending `req`[3] is granted via CLEAR with requester 0 back at top priority.
